// File: rtl/fpnew_pkg.sv
// Shared FPnew types: IEEE exception flags reported with each result.
package fpnew_pkg;

    typedef struct packed {
        logic nv; // invalid operation
        logic dz; // divide by zero
        logic of; // overflow
        logic uf; // underflow
        logic nx; // inexact
    } status_t;

endpackage

// File: rtl/fpnew_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr_i, ascending with wrap.
module fpnew_rr_arbiter #(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxW = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_c,
    output logic [IdxW-1:0]   idx_c,
    output logic              any_c
);

    int unsigned      cand;
    logic [IdxW-1:0]  cand_idx;

    // Scan from the pointer; the first hit wins and masks the rest.
    always_comb begin
        gnt_c    = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand     = (32'(ptr_i) + k) % NumReq;
            cand_idx = IdxW'(cand);
            if (!any_c && req_i[cand_idx]) begin
                any_c           = 1'b1;
                gnt_c[cand_idx] = 1'b1;
                idx_c           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fpnew_slice_result_arbiter.sv
// Merges per-format slice results into one registered output stage.
module fpnew_slice_result_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumSlices = 4,
    parameter int unsigned Width     = 32,
    parameter type         TagType   = logic,
    localparam int unsigned IdxW     = $clog2(NumSlices)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumSlices-1:0][Width-1:0] slice_result_i,
    input  status_t [NumSlices-1:0]         slice_status_i,
    input  logic [NumSlices-1:0]            slice_ext_bit_i,
    input  TagType                          slice_tag_i [NumSlices],
    input  logic [NumSlices-1:0]            slice_valid_i,
    output logic [NumSlices-1:0]            slice_ready_o,
    input  logic                            flush_i,
    output logic [Width-1:0]                result_o,
    output status_t                         status_o,
    output logic                            extension_bit_o,
    output TagType                          tag_o,
    output logic [IdxW-1:0]                 slice_idx_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            busy_o
);

    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] result_q,    result_d;
    status_t          status_q,    status_d;
    logic             ext_q,       ext_d;
    TagType           tag_q,       tag_d;
    logic [IdxW-1:0]  idx_q,       idx_d;
    logic [IdxW-1:0]  ptr_q,       ptr_d;

    logic                 accept_c;
    logic                 arb_en_c;
    logic [NumSlices-1:0] req_c;
    logic [NumSlices-1:0] gnt_c;
    logic [IdxW-1:0]      gnt_idx_c;
    logic                 gnt_any_c;

    // Output stage can take a new result when empty or being drained.
    assign accept_c = ~out_valid_q | out_ready_i;
    assign arb_en_c = accept_c & ~flush_i & ~rst_i;
    assign req_c    = slice_valid_i & {NumSlices{arb_en_c}};

    fpnew_rr_arbiter #(
        .NumReq (NumSlices)
    ) i_rr_arbiter (
        .req_i (req_c),
        .ptr_i (ptr_q),
        .gnt_c (gnt_c),
        .idx_c (gnt_idx_c),
        .any_c (gnt_any_c)
    );

    assign slice_ready_o = gnt_c;

    // Next state: flush drops, grant captures, drain empties, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        status_d    = status_q;
        ext_d       = ext_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (gnt_any_c) begin
            out_valid_d = 1'b1;
            result_d    = slice_result_i[gnt_idx_c];
            status_d    = slice_status_i[gnt_idx_c];
            ext_d       = slice_ext_bit_i[gnt_idx_c];
            tag_d       = slice_tag_i[gnt_idx_c];
            idx_d       = gnt_idx_c;
            ptr_d       = (gnt_idx_c == IdxW'(NumSlices - 1)) ? '0
                                                              : gnt_idx_c + IdxW'(1);
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_q       <= 1'b0;
            tag_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            status_q    <= status_d;
            ext_q       <= ext_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign busy_o          = out_valid_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign slice_idx_o     = idx_q;

endmodule

// File: tb/tb_fpnew_slice_result_arbiter.sv
// Directed bench for the slice result arbiter (4 slices, 32-bit, 4-bit tag).
module tb_fpnew_slice_result_arbiter;
    import fpnew_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [3:0][31:0]     slice_result;
    status_t [3:0]        slice_status;
    logic [3:0]           slice_ext;
    logic [3:0]           slice_tag [4];
    logic [3:0]           slice_valid;
    logic [3:0]           slice_ready;
    logic                 flush_i;
    logic [31:0]          result_o;
    status_t              status_o;
    logic                 extension_bit_o;
    logic [3:0]           tag_o;
    logic [1:0]           slice_idx_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] res_v [4];
    status_t     st_v  [4];
    logic [3:0]  tag_v [4];
    logic        ext_v [4];

    fpnew_slice_result_arbiter #(
        .NumSlices (4),
        .Width     (32),
        .TagType   (logic [3:0])
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .slice_result_i  (slice_result),
        .slice_status_i  (slice_status),
        .slice_ext_bit_i (slice_ext),
        .slice_tag_i     (slice_tag),
        .slice_valid_i   (slice_valid),
        .slice_ready_o   (slice_ready),
        .flush_i         (flush_i),
        .result_o        (result_o),
        .status_o        (status_o),
        .extension_bit_o (extension_bit_o),
        .tag_o           (tag_o),
        .slice_idx_o     (slice_idx_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; slice_valid = 4'b1111;
        #1;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL rst_ready got=%b exp=0000", slice_ready); else n_pass++;
        tick; tick;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL rst_result got=%h exp=0", result_o); else n_pass++;
        n_checks++; if (status_o !== 5'h0) $display("FAIL rst_status got=%h exp=0", status_o); else n_pass++;
        n_checks++; if (extension_bit_o !== 1'b0) $display("FAIL rst_ext got=%b exp=0", extension_bit_o); else n_pass++;
        n_checks++; if (tag_o !== 4'h0) $display("FAIL rst_tag got=%h exp=0", tag_o); else n_pass++;
        n_checks++; if (slice_idx_o !== 2'd0) $display("FAIL rst_idx got=%0d exp=0", slice_idx_o); else n_pass++;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL rst_ready_hold got=%b exp=0000", slice_ready); else n_pass++;
        rst_i = 1'b0; slice_valid = 4'b0000;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy;
        int e;
        slice_valid = 4'b1111; out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            exp_rdy = 4'b0001 << e;
            #1;
            n_checks++; if (slice_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got=%b exp=%b", k, slice_ready, exp_rdy); else n_pass++;
            tick;
            n_checks++; if (out_valid_o !== 1'b1) $display("FAIL rr_valid[%0d] got=%b exp=1", k, out_valid_o); else n_pass++;
            n_checks++; if (slice_idx_o !== 2'(e)) $display("FAIL rr_idx[%0d] got=%0d exp=%0d", k, slice_idx_o, e); else n_pass++;
            n_checks++; if (result_o !== res_v[e]) $display("FAIL rr_result[%0d] got=%h exp=%h", k, result_o, res_v[e]); else n_pass++;
            n_checks++; if (tag_o !== tag_v[e]) $display("FAIL rr_tag[%0d] got=%h exp=%h", k, tag_o, tag_v[e]); else n_pass++;
            n_checks++; if (status_o !== st_v[e]) $display("FAIL rr_status[%0d] got=%h exp=%h", k, status_o, st_v[e]); else n_pass++;
            n_checks++; if (extension_bit_o !== ext_v[e]) $display("FAIL rr_ext[%0d] got=%b exp=%b", k, extension_bit_o, ext_v[e]); else n_pass++;
        end
        slice_valid = 4'b0000;
        #1;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL drain_ready got=%b exp=0000", slice_ready); else n_pass++;
        tick;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL drain_valid got=%b exp=0", out_valid_o); else n_pass++;
    endtask

    // pointer is 1 on entry
    task automatic test_hold;
        slice_valid = 4'b0100; out_ready_i = 1'b0;
        #1;
        n_checks++; if (slice_ready !== 4'b0100) $display("FAIL hold_ready0 got=%b exp=0100", slice_ready); else n_pass++;
        tick;
        n_checks++; if (slice_idx_o !== 2'd2) $display("FAIL hold_idx got=%0d exp=2", slice_idx_o); else n_pass++;
        slice_result[2] = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (slice_ready !== 4'b0000) $display("FAIL hold_ready[%0d] got=%b exp=0000", k, slice_ready); else n_pass++;
            tick;
            n_checks++; if (out_valid_o !== 1'b1) $display("FAIL hold_valid[%0d] got=%b exp=1", k, out_valid_o); else n_pass++;
            n_checks++; if (result_o !== res_v[2]) $display("FAIL hold_result[%0d] got=%h exp=%h", k, result_o, res_v[2]); else n_pass++;
            n_checks++; if (tag_o !== tag_v[2]) $display("FAIL hold_tag[%0d] got=%h exp=%h", k, tag_o, tag_v[2]); else n_pass++;
        end
        slice_result[2] = res_v[2];
        slice_valid = 4'b0000; out_ready_i = 1'b1;
        tick;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL hold_drain got=%b exp=0", out_valid_o); else n_pass++;
    endtask

    // pointer is 3 on entry
    task automatic test_wrap;
        slice_valid = 4'b1001; out_ready_i = 1'b1;
        #1;
        n_checks++; if (slice_ready !== 4'b1000) $display("FAIL wrap_ready0 got=%b exp=1000", slice_ready); else n_pass++;
        tick;
        n_checks++; if (slice_idx_o !== 2'd3) $display("FAIL wrap_idx0 got=%0d exp=3", slice_idx_o); else n_pass++;
        #1;
        n_checks++; if (slice_ready !== 4'b0001) $display("FAIL wrap_ready1 got=%b exp=0001", slice_ready); else n_pass++;
        tick;
        n_checks++; if (slice_idx_o !== 2'd0) $display("FAIL wrap_idx1 got=%0d exp=0", slice_idx_o); else n_pass++;
        n_checks++; if (result_o !== res_v[0]) $display("FAIL wrap_result got=%h exp=%h", result_o, res_v[0]); else n_pass++;
        slice_valid = 4'b0000;
        tick;
    endtask

    // pointer is 1 on entry
    task automatic test_flush;
        slice_valid = 4'b0010; out_ready_i = 1'b0;
        tick;
        n_checks++; if (slice_idx_o !== 2'd1 || out_valid_o !== 1'b1) $display("FAIL flush_pre got idx=%0d v=%b exp idx=1 v=1", slice_idx_o, out_valid_o); else n_pass++;
        flush_i = 1'b1;
        #1;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL flush_ready got=%b exp=0000", slice_ready); else n_pass++;
        tick;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy_o); else n_pass++;
        flush_i = 1'b0;
        #1;
        n_checks++; if (slice_ready !== 4'b0010) $display("FAIL flush_regrant_ready got=%b exp=0010", slice_ready); else n_pass++;
        tick;
        n_checks++; if (out_valid_o !== 1'b1 || slice_idx_o !== 2'd1) $display("FAIL flush_regrant got v=%b idx=%0d exp v=1 idx=1", out_valid_o, slice_idx_o); else n_pass++;
        // pointer now 2; a flush with all requesting must not move it
        slice_valid = 4'b1111; out_ready_i = 1'b1; flush_i = 1'b1;
        #1;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL flush_all_ready got=%b exp=0000", slice_ready); else n_pass++;
        tick;
        flush_i = 1'b0;
        #1;
        n_checks++; if (slice_ready !== 4'b0100) $display("FAIL flush_ptr_kept got=%b exp=0100", slice_ready); else n_pass++;
        tick;
        n_checks++; if (slice_idx_o !== 2'd2) $display("FAIL flush_ptr_idx got=%0d exp=2", slice_idx_o); else n_pass++;
        slice_valid = 4'b0000;
        tick;
    endtask

    // pointer is 3 on entry
    task automatic test_reset_mid;
        slice_valid = 4'b0100; out_ready_i = 1'b0;
        tick;
        n_checks++; if (out_valid_o !== 1'b1 || slice_idx_o !== 2'd2) $display("FAIL rmid_pre got v=%b idx=%0d exp v=1 idx=2", out_valid_o, slice_idx_o); else n_pass++;
        rst_i = 1'b1; slice_valid = 4'b1111;
        #1;
        n_checks++; if (slice_ready !== 4'b0000) $display("FAIL rmid_ready got=%b exp=0000", slice_ready); else n_pass++;
        tick;
        n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", out_valid_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy_o); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL rmid_result got=%h exp=0", result_o); else n_pass++;
        rst_i = 1'b0; out_ready_i = 1'b1;
        #1;
        n_checks++; if (slice_ready !== 4'b0001) $display("FAIL rmid_ptr_ready got=%b exp=0001", slice_ready); else n_pass++;
        tick;
        n_checks++; if (out_valid_o !== 1'b1 || slice_idx_o !== 2'd0) $display("FAIL rmid_grant got v=%b idx=%0d exp v=1 idx=0", out_valid_o, slice_idx_o); else n_pass++;
        slice_valid = 4'b0000;
        tick;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            res_v[i] = 32'hA000_0000 | 32'(i * 17 + 3);
            st_v[i]  = 5'(i * 3 + 1);
            tag_v[i] = 4'(i + 5);
            ext_v[i] = (i % 2) == 1;
            slice_result[i] = res_v[i];
            slice_status[i] = st_v[i];
            slice_tag[i]    = tag_v[i];
            slice_ext[i]    = ext_v[i];
        end
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; slice_valid = 4'b0000;
        test_reset;
        test_round_robin;
        test_hold;
        test_wrap;
        test_flush;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpnew_slice_result_arbiter.md
FPNEW_SLICE_RESULT_ARBITER -- requirements
Module: fpnew_slice_result_arbiter

Interface
REQ-001 SHALL have parameter NumSlices, default 4; number of format-slice result ports (2..8).
REQ-002 SHALL have parameter Width, default 32; result width in bits.
REQ-003 SHALL have parameter TagType, default logic; opaque tag type carried with each result.
REQ-004 SHALL have port clk_i, input, 1; the single clock, with all state updated on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset, synchronous and active-high.
REQ-006 SHALL have port slice_result_i, input, NumSlices x Width; per-slice result.
REQ-007 SHALL have port slice_status_i, input, NumSlices x fpnew_pkg::status_t; per-slice flags.
REQ-008 SHALL have port slice_ext_bit_i, input, NumSlices; per-slice extension bit.
REQ-009 SHALL have port slice_tag_i, input, NumSlices x TagType; per-slice tag.
REQ-010 SHALL have port slice_valid_i, input, NumSlices; per-slice out_valid.
REQ-011 SHALL have port slice_ready_o, output, NumSlices; per-slice out_ready.
REQ-012 SHALL have port flush_i, input, 1; drops any held result.
REQ-013 SHALL have ports result_o (Width), status_o (status_t), extension_bit_o (1), tag_o (TagType), outputs; the registered winning result.
REQ-014 SHALL have port slice_idx_o, output, $clog2(NumSlices); index of the slice that produced the held result.
REQ-015 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1); downstream handshake.
REQ-016 SHALL have port busy_o, output, 1; high while a result is held.

Function
REQ-017 SHALL define accept = ~out_valid_o | out_ready_i, evaluated combinationally in the same cycle.
REQ-018 SHALL grant at most one slice per cycle, and only when accept=1 and flush_i=0.
REQ-019 SHALL use round-robin arbitration: search begins at pointer ptr, ascending, wrapping from NumSlices-1 to 0.
REQ-020 SHALL drive slice_ready_o[i]=1 only for the granted slice i and 0 for all others.
REQ-021 SHALL on a grant to slice i capture result/status/ext/tag/i into the output register and set ptr=(i+1) mod NumSlices at the next edge.
REQ-022 SHALL have latency of exactly one cycle from the slice handshake to out_valid_o=1.
REQ-023 SHALL sustain one result per cycle when out_ready_i is held high (full throughput, no bubble).
REQ-024 SHALL hold all outputs stable while out_valid_o=1 and out_ready_i=0.
REQ-025 SHALL clear out_valid_o at the next edge if out_ready_i=1 and no grant occurs.
REQ-026 SHALL in a cycle with flush_i=1 drive all slice_ready_o=0, clear out_valid_o at the next edge, and leave ptr unchanged.
REQ-027 SHALL leave ptr unchanged in any cycle without a grant.
REQ-028 SHALL tie busy_o to out_valid_o.

Reset
REQ-029 SHALL on rst_i=1 at a clock edge set out_valid_o=0, ptr=0, and result_o, status_o, extension_bit_o, tag_o and slice_idx_o to 0.
REQ-030 SHALL give rst_i priority over flush_i and over any grant; a result being handshaken in the reset cycle is lost.
REQ-031 SHALL drive all slice_ready_o=0 while rst_i=1.

Structure
REQ-032 SHALL take status_t from fpnew_pkg and SHALL NOT add new package typedefs; the index width is a local constant.
REQ-033 SHALL place round-robin grant logic in a sub-module named fpnew_rr_arbiter (request vector, pointer in, one-hot grant plus index out).

Verification
REQ-034 SHALL test NumSlices=4 with all valid held high and out_ready_i=1: grants are 0,1,2,3,0 on consecutive cycles, and out_valid_o stays 1 from cycle 2 onward.
REQ-035 SHALL test only slice 2 valid with out_ready_i=0 for 3 cycles: result_o is stable for those 3 cycles and slice_ready_o=0000 after the capture.
REQ-036 SHALL test ptr=3 with valid=1001: slice 3 is granted, then slice 0 (wrap-around).
REQ-037 SHALL test flush_i=1 while holding a result, with slice 1 valid: slice_ready_o=0000, out_valid_o=0 on the next cycle, and slice 1 is granted in the following cycle.
REQ-038 SHALL test rst_i=1 while out_valid_o=1 and out_ready_i=0: next cycle out_valid_o=0, busy_o=0, and the next grant begins at slice 0.
